// File: rtl/axi_lite_ctrl_regs_if.sv
// AXI4-Lite configuration bus bundle for axi_lite_ctrl_regs.
// The master modport is the host/config side; the slave modport is the register file.
interface axi_lite_ctrl_regs_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_ctrl_regs.sv
// axi_lite_ctrl_regs: AXI4-Lite register file in front of an HLS accelerator.
// Holds kernel parameters, the start/done control register and a run-cycle counter.
// Optional feature macro: AXI_LITE_CTRL_IRQ_EN (IER at 0x08 and the irq output).
//
// state  | meaning
// W_IDLE | collecting AW and W into holding regs; commits once both are held
// W_RESP | BVALID high with registered BRESP, waiting for BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high with registered RDATA/RRESP, waiting for RREADY
module axi_lite_ctrl_regs #(
    parameter int NUM_PARAMS = 8,
    parameter int ADDR_W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    axi_lite_ctrl_regs_if.slave       bus,
    output logic                      ap_start,
    input  logic                      ap_done,
    output logic [32*NUM_PARAMS-1:0]  params,
    output logic                      irq
);
    localparam int         WA_W        = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {A_CTRL, A_STATUS, A_IER, A_PARAM, A_NONE} addr_kind_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Word-address decode shared by the read and write paths.
    function automatic addr_kind_t decode(input logic [WA_W-1:0] waddr);
        int widx;
        widx = 32'(waddr);
        if (widx == 0) return A_CTRL;
        if (widx == 1) return A_STATUS;
`ifdef AXI_LITE_CTRL_IRQ_EN
        if (widx == 2) return A_IER;
`endif
        if (widx >= 4 && widx < 4 + NUM_PARAMS) return A_PARAM;
        return A_NONE;
    endfunction

    w_state_t          w_state, w_state_next;
    r_state_t          r_state, r_state_next;
    logic              ready_en;
    logic              aw_held, w_held;
    logic [WA_W-1:0]   aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;
    logic              busy, done;
    logic [31:0]       cycle_cnt;
    logic [31:0]       param_q [NUM_PARAMS];
`ifdef AXI_LITE_CTRL_IRQ_EN
    logic              ier;
`endif

    logic              aw_ready, w_ready, ar_ready, do_write, ar_hs;
    addr_kind_t        w_kind, r_kind;
    int                w_pidx, r_pidx;
    logic [1:0]        w_resp, rd_resp;
    logic [31:0]       rd_data;

    // Only the decoded address bits matter; the rest are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.AWADDR[31:ADDR_W], bus.AWADDR[1:0],
                                bus.ARADDR[31:ADDR_W], bus.ARADDR[1:0]};

    assign aw_ready = ready_en & ~aw_held & (w_state == W_IDLE);
    assign w_ready  = ready_en & ~w_held & (w_state == W_IDLE);
    assign ar_ready = ready_en & (r_state == R_IDLE);
    assign do_write = (w_state == W_IDLE) & aw_held & w_held;
    assign ar_hs    = bus.ARVALID & ar_ready;

    assign bus.AWREADY = aw_ready;
    assign bus.WREADY  = w_ready;
    assign bus.BVALID  = (w_state == W_RESP);
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = ar_ready;
    assign bus.RVALID  = (r_state == R_DATA);
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign ap_start    = busy;

    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_params
        assign params[32*gi +: 32] = param_q[gi];
    end

    // Readies stay low through reset and rise the cycle after it releases.
    always_ff @(posedge clk) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    // Independent capture of write address and write data.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (bus.AWVALID && aw_ready) begin
                aw_held   <= 1'b1;
                aw_addr_q <= bus.AWADDR[ADDR_W-1:2];
            end else if (do_write) begin
                aw_held <= 1'b0;
            end
            if (bus.WVALID && w_ready) begin
                w_held   <= 1'b1;
                w_data_q <= bus.WDATA;
                w_strb_q <= bus.WSTRB;
            end else if (do_write) begin
                w_held <= 1'b0;
            end
        end
    end

    // Write-side decode and response code for the pending commit.
    always_comb begin
        w_kind = decode(aw_addr_q);
        w_pidx = 32'(aw_addr_q) - 32'd4;
        w_resp = RESP_OKAY;
        if (w_kind == A_NONE || (w_kind == A_PARAM && busy)) w_resp = RESP_SLVERR;
    end

    // Write FSM state register and response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
        end else begin
            w_state <= w_state_next;
            if (do_write) bresp_q <= w_resp;
        end
    end

    // Write FSM next state.
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (do_write) w_state_next = W_RESP;
            W_RESP:  if (bus.BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Run control: ap_done is applied before the write so a coincident done is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            if (busy && cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
            if (busy && ap_done) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (do_write && w_kind == A_CTRL) begin
                if (w_data_q[0] && !busy) begin
                    busy      <= 1'b1;
                    cycle_cnt <= '0;
                end
                if (w_data_q[1] && !(busy && ap_done)) done <= 1'b0;
            end
        end
    end

    // Parameter registers with byte-lane writes, frozen while the kernel runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) param_q[i] <= '0;
        end else if (do_write && w_kind == A_PARAM && !busy) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (w_pidx == i) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_q[b]) param_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef AXI_LITE_CTRL_IRQ_EN
    // Interrupt enable and registered interrupt, one edge behind done.
    always_ff @(posedge clk) begin
        if (reset) begin
            ier <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (do_write && w_kind == A_IER) ier <= w_data_q[0];
            irq <= ier & done;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux on the live address; sampled into RDATA at the AR handshake.
    always_comb begin
        r_kind  = decode(bus.ARADDR[ADDR_W-1:2]);
        r_pidx  = 32'(bus.ARADDR[ADDR_W-1:2]) - 32'd4;
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (r_kind)
            A_CTRL:   rd_data = {30'b0, done, busy};
            A_STATUS: rd_data = cycle_cnt;
`ifdef AXI_LITE_CTRL_IRQ_EN
            A_IER:    rd_data = {31'b0, ier};
`endif
            A_PARAM: begin
                for (int i = 0; i < NUM_PARAMS; i++) begin
                    if (r_pidx == i) rd_data = param_q[i];
                end
            end
            default:  rd_resp = RESP_SLVERR;
        endcase
    end

    // Read FSM state register and read data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (bus.RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end
endmodule
